led_rotate_ctrl: RTL and testbench

Command-driven sequencer for the 4-LED one-hot rotation display.
- Replaces the free-running rotation with a controlled scheduler: start, pause, halt, direction and speed are set through a valid/ready command port.
- Generates the per-step timing internally with a reloadable down-counter clocked on clk.
- Sits between the board-level button/command logic and the LED pins.

---
 rtl/led_rotate_ctrl_if.sv | 23 ++
 rtl/led_rotate_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_led_rotate_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_rotate_ctrl_if.sv
// led_rotate_ctrl_if: valid/ready command port of the LED rotation sequencer.
// The master (button/command logic) drives the command, the slave (the
// sequencer) answers with cmd_ready.
interface led_rotate_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/led_rotate_ctrl.sv
// led_rotate_ctrl: command-driven scheduler for the 4-LED one-hot rotation.
// START/PAUSE/HALT/CONFIG arrive on a valid/ready port; each LED step lasts
// TICK_BASE << spd clock cycles, timed by a reloadable down-counter.
// Optional bounce mode (LED reverses at the end LEDs) is compiled in only
// when the macro LED_BOUNCE_EN is defined.
module led_rotate_ctrl #(
    parameter int TICK_BASE = 25000,
    parameter int CNT_W     = 20
) (
    input  logic                clk,
    input  logic                reset,
    led_rotate_ctrl_if.slave    cmd,
    output logic [3:0]          led,
    output logic                busy,
    output logic                step,
    output logic [7:0]          rev_cnt,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_CONFIG = 2'b11;

    state_t             state_q, state_d;
    logic [3:0]         led_q, led_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [1:0]         spd_q, spd_d;
    logic [7:0]         rev_q, rev_d;
    logic               step_q, step_d;
    logic               ready_q, ready_d;

`ifdef LED_BOUNCE_EN
    logic               bounce_q, bounce_d;
`else
    logic               unused_bounce_arg;
    assign unused_bounce_arg = cmd.cmd_arg[3];
`endif

    logic               accept;
    logic               is_cfg;
    logic               is_ctl;
    logic [3:0]         adv_led;
    logic               adv_dir;
    logic               adv_rev;

    // Step period minus one for a given speed code; the reload value of cnt.
    function automatic logic [CNT_W-1:0] period_m1(input logic [1:0] s);
        return (CNT_W'(TICK_BASE) << s) - CNT_W'(1);
    endfunction

    // First LED lit for a given direction; also the revolution marker.
    function automatic logic [3:0] start_pat(input logic d);
        return d ? 4'b0001 : 4'b1000;
    endfunction

    assign accept = cmd.cmd_valid && ready_q;
    assign is_cfg = accept && (cmd.cmd_op == OP_CONFIG);
    assign is_ctl = accept && (cmd.cmd_op != OP_CONFIG);

    // Where the LED goes on the next advance, and whether that completes a revolution.
    always_comb begin
        adv_dir = dir_q;
        adv_led = dir_q ? {led_q[2:0], led_q[3]} : {led_q[0], led_q[3:1]};
        adv_rev = 1'b0;
`ifdef LED_BOUNCE_EN
        if (bounce_q && !dir_q && (led_q == 4'b0001)) begin
            adv_dir = 1'b1;
            adv_led = 4'b0010;
            adv_rev = 1'b1;
        end else if (bounce_q && dir_q && (led_q == 4'b1000)) begin
            adv_dir = 1'b0;
            adv_led = 4'b0100;
            adv_rev = 1'b1;
        end else begin
            adv_rev = (adv_led == start_pat(dir_q));
        end
`else
        adv_rev = (adv_led == start_pat(dir_q));
`endif
    end

    // Next-state logic: control commands pre-empt the count, CONFIG rides alongside it.
    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        spd_d    = spd_q;
        rev_d    = rev_q;
        step_d   = 1'b0;
        ready_d  = !accept;
`ifdef LED_BOUNCE_EN
        bounce_d = bounce_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (is_ctl && (cmd.cmd_op == OP_START)) begin
                    state_d = ST_RUN;
                    led_d   = start_pat(dir_q);
                    cnt_d   = period_m1(spd_q);
                end
            end
            ST_RUN: begin
                if (is_ctl) begin
                    case (cmd.cmd_op)
                        OP_START: begin
                            led_d = start_pat(dir_q);
                            cnt_d = period_m1(spd_q);
                        end
                        OP_PAUSE: begin
                            state_d = ST_PAUSE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            led_d   = 4'b0000;
                            cnt_d   = '0;
                        end
                    endcase
                end else if (cnt_q == '0) begin
                    led_d  = adv_led;
                    dir_d  = adv_dir;
                    cnt_d  = period_m1(spd_q);
                    step_d = 1'b1;
                    if (adv_rev) begin
                        rev_d = rev_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (is_ctl && (cmd.cmd_op == OP_START)) begin
                    state_d = ST_RUN;
                end else if (is_ctl && (cmd.cmd_op == OP_HALT)) begin
                    state_d = ST_IDLE;
                    led_d   = 4'b0000;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 4'b0000;
                cnt_d   = '0;
            end
        endcase

        if (is_cfg) begin
            dir_d    = cmd.cmd_arg[0];
            spd_d    = cmd.cmd_arg[2:1];
`ifdef LED_BOUNCE_EN
            bounce_d = cmd.cmd_arg[3];
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            led_q    <= 4'b0000;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            spd_q    <= 2'b00;
            rev_q    <= 8'd0;
            step_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef LED_BOUNCE_EN
            bounce_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            spd_q    <= spd_d;
            rev_q    <= rev_d;
            step_q   <= step_d;
            ready_q  <= ready_d;
`ifdef LED_BOUNCE_EN
            bounce_q <= bounce_d;
`endif
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign led           = led_q;
    assign busy          = (state_q != ST_IDLE);
    assign step          = step_q;
    assign rev_cnt       = rev_q;
    assign state         = state_q;

endmodule

// File: tb/tb_led_rotate_ctrl.sv
// tb_led_rotate_ctrl: directed self-checking bench for led_rotate_ctrl with
// TICK_BASE=4. Expected values are hand-computed from the command sequence.
// The bounce-mode section runs only when LED_BOUNCE_EN is defined.
module tb_led_rotate_ctrl;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_CONFIG = 2'b11;

    logic       clk;
    logic       reset;
    logic [3:0] led;
    logic       busy;
    logic       step;
    logic [7:0] rev_cnt;
    logic [1:0] state;

    int compared;
    int mismatched;

    led_rotate_ctrl_if cmd_if ();

    led_rotate_ctrl #(
        .TICK_BASE (4),
        .CNT_W     (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd_if.slave),
        .led     (led),
        .busy    (busy),
        .step    (step),
        .rev_cnt (rev_cnt),
        .state   (state)
    );

    // 10 ns free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command, waiting (bounded) for cmd_ready; returns just after acceptance.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] arg);
        int guard;
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 8) begin
            tick();
            guard++;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Count edges until a step pulse is seen, giving up after max_cycles.
    task automatic waitStep(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < max_cycles);
    endtask

    initial begin
        int         n;
        logic       step_seen;
        logic [3:0] b_led [7];
        logic [7:0] b_rev [7];

        compared         = 0;
        mismatched       = 0;
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_arg   = 4'b0000;
        ticks(2);
        reset = 1'b0;

        // Reset values
        checkOutput("rst_led",   led, 4'b0000);
        checkOutput("rst_busy",  busy, 1'b0);
        checkOutput("rst_state", state, 2'b00);
        checkOutput("rst_rev",   rev_cnt, 8'd0);
        checkOutput("rst_step",  step, 1'b0);
        checkOutput("rst_ready", cmd_if.cmd_ready, 1'b1);

        // START and four steps of 4 cycles each
        applyStimulus(OP_START, 4'b0000);
        checkOutput("start_led",   led, 4'b1000);
        checkOutput("start_busy",  busy, 1'b1);
        checkOutput("start_state", state, 2'b01);
        checkOutput("start_ready_low", cmd_if.cmd_ready, 1'b0);
        tick();
        checkOutput("start_ready_back", cmd_if.cmd_ready, 1'b1);
        checkOutput("start_no_step", step, 1'b0);
        n = 0;
        while (!step && n < 10) begin
            tick();
            n++;
        end
        checkOutput("step1_gap", n + 1, 4);
        checkOutput("step1_led", led, 4'b0100);
        waitStep(20, n);
        checkOutput("step2_gap", n, 4);
        checkOutput("step2_led", led, 4'b0010);
        waitStep(20, n);
        checkOutput("step3_gap", n, 4);
        checkOutput("step3_led", led, 4'b0001);
        checkOutput("step3_rev", rev_cnt, 8'd0);
        waitStep(20, n);
        checkOutput("step4_gap", n, 4);
        checkOutput("step4_led", led, 4'b1000);
        checkOutput("step4_rev", rev_cnt, 8'd1);

        // CONFIG dir 1 spd 1 mid-step: current step keeps its 4-cycle length
        tick();
        applyStimulus(OP_CONFIG, 4'b0011);
        checkOutput("cfg_ready_low", cmd_if.cmd_ready, 1'b0);
        waitStep(20, n);
        checkOutput("cfg_inflight_gap", n, 2);
        checkOutput("cfg_wrap_led", led, 4'b0001);
        checkOutput("cfg_wrap_rev", rev_cnt, 8'd2);
        waitStep(20, n);
        checkOutput("spd1_gap_a", n, 8);
        checkOutput("spd1_led_a", led, 4'b0010);
        waitStep(20, n);
        checkOutput("spd1_gap_b", n, 8);
        checkOutput("spd1_led_b", led, 4'b0100);

        // PAUSE with cnt=2, hold 10 cycles, then resume
        ticks(5);
        applyStimulus(OP_PAUSE, 4'b0000);
        checkOutput("pause_state", state, 2'b10);
        checkOutput("pause_busy", busy, 1'b1);
        step_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) step_seen = 1'b1;
            checkOutput("pause_led", led, 4'b0100);
        end
        checkOutput("pause_no_step", step_seen, 1'b0);
        applyStimulus(OP_START, 4'b0000);
        checkOutput("resume_state", state, 2'b01);
        waitStep(20, n);
        checkOutput("resume_gap", n, 3);
        checkOutput("resume_led", led, 4'b1000);
        applyStimulus(OP_HALT, 4'b0000);
        checkOutput("halt_led", led, 4'b0000);
        checkOutput("halt_state", state, 2'b00);
        checkOutput("halt_busy", busy, 1'b0);
        checkOutput("halt_rev", rev_cnt, 8'd2);

        // HALT exactly at cnt==0 suppresses the step
        applyStimulus(OP_START, 4'b0000);
        checkOutput("rs_led", led, 4'b0001);
        ticks(7);
        applyStimulus(OP_HALT, 4'b0000);
        checkOutput("halt0_step", step, 1'b0);
        checkOutput("halt0_led", led, 4'b0000);
        checkOutput("halt0_state", state, 2'b00);

        // CONFIG at cnt==0: step uses old dir/spd, new spd from the next reload
        applyStimulus(OP_START, 4'b0000);
        ticks(7);
        applyStimulus(OP_CONFIG, 4'b0000);
        checkOutput("cfg0_step", step, 1'b1);
        checkOutput("cfg0_led", led, 4'b0010);
        waitStep(20, n);
        checkOutput("cfg0_old_gap", n, 8);
        checkOutput("cfg0_newdir_led", led, 4'b0001);
        waitStep(20, n);
        checkOutput("cfg0_new_gap", n, 4);
        checkOutput("cfg0_rev", rev_cnt, 8'd3);

        // Reset during RUN at led 0010
        waitStep(20, n);
        waitStep(20, n);
        checkOutput("pre_rst_led", led, 4'b0010);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_led",   led, 4'b0000);
        checkOutput("mid_rst_state", state, 2'b00);
        checkOutput("mid_rst_busy",  busy, 1'b0);
        checkOutput("mid_rst_step",  step, 1'b0);
        checkOutput("mid_rst_rev",   rev_cnt, 8'd0);
        checkOutput("mid_rst_ready", cmd_if.cmd_ready, 1'b1);

        // 256 revolutions wrap rev_cnt
        applyStimulus(OP_START, 4'b0000);
        ticks(4080);
        checkOutput("rev255", rev_cnt, 8'd255);
        checkOutput("rev255_led", led, 4'b1000);
        ticks(16);
        checkOutput("rev_wrap", rev_cnt, 8'd0);
        checkOutput("rev_wrap_led", led, 4'b1000);

        // Unaccepted command has no effect; PAUSE in IDLE accepted but ignored
        applyStimulus(OP_HALT, 4'b0000);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_START;
        tick();
        cmd_if.cmd_valid = 1'b0;
        checkOutput("unacc_state", state, 2'b00);
        checkOutput("unacc_led", led, 4'b0000);
        checkOutput("unacc_ready", cmd_if.cmd_ready, 1'b1);
        applyStimulus(OP_PAUSE, 4'b0000);
        checkOutput("idle_pause_state", state, 2'b00);
        checkOutput("idle_pause_ready", cmd_if.cmd_ready, 1'b0);

`ifdef LED_BOUNCE_EN
        // Bounce mode sequence
        b_led = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        b_rev = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(OP_CONFIG, 4'b1000);
        applyStimulus(OP_START, 4'b0000);
        checkOutput("bnc_start_led", led, 4'b1000);
        for (int i = 0; i < 7; i++) begin
            waitStep(20, n);
            checkOutput("bnc_led", led, b_led[i]);
            checkOutput("bnc_rev", rev_cnt, b_rev[i]);
        end
`else
        b_led = '{default: 4'b0000};
        b_rev = '{default: 8'd0};
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
